// File: rtl/alu_pkg.sv
// Shared ALU control-code contract used by the control decoder and the execution unit.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic zero;
    logic overflow;
    logic illegal;
  } alu_flags_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) ||
           (op == ALU_OR)  || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_exec_unit_core.sv
// Combinational ALU: maps (op, a, b) to result, signed overflow and illegal-code flag.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             illegal
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             v_add;
  logic             v_sub;

  // Subtraction shares one adder form (A + ~B + 1); carry-out is dropped.
  assign sum   = a + b;
  assign diff  = a + ~b + WIDTH'(1);
  assign v_add = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
  assign v_sub = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    illegal  = !is_legal_op(op);
    case (op)
      ALU_ADD: begin
        result   = sum;
        overflow = v_add;
      end
      ALU_SUB: begin
        result   = diff;
        overflow = v_sub;
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      // Signed less-than from the subtractor: N xor V; overflow itself is not reported.
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, diff[MSB] ^ v_sub};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Two-stage valid/ready ALU execution pipeline with completed-operation counter.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic [CNT_W-1:0] op_count
);

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic [WIDTH-1:0] core_result;
  logic             core_overflow;
  logic             core_illegal;

  alu_flags_t       s2_flags;

  logic             s1_load;
  logic             s2_load;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op       (s1_op),
    .a        (s1_a),
    .b        (s1_b),
    .result   (core_result),
    .overflow (core_overflow),
    .illegal  (core_illegal)
  );

  // S2 refills in the same edge it drains, so a full pipe streams without bubbles.
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign s1_load  = in_valid && in_ready;

  assign zero     = s2_flags.zero;
  assign overflow = s2_flags.overflow;
  assign illegal  = s2_flags.illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_op     <= 3'b000;
      s1_a      <= '0;
      s1_b      <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      s2_flags  <= '0;
      op_count  <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_op    <= alu_control;
        s1_a     <= src_a;
        s1_b     <= src_b;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      if (s2_load) begin
        out_valid         <= 1'b1;
        result            <= core_result;
        s2_flags.zero     <= (core_result == '0);
        s2_flags.overflow <= core_overflow;
        s2_flags.illegal  <= core_illegal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (out_valid && out_ready) begin
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: driver pushes model results, monitor pops on handshake.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    alu_control;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero;
  logic          overflow;
  logic          illegal;
  logic [CW-1:0] op_count;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .overflow    (overflow),
    .illegal     (illegal),
    .op_count    (op_count)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         ov;
    logic         il;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          passes = 0;
  int unsigned cnt = 0;
  bit          done = 0;

  logic         hold_v = 1'b0;
  logic [W-1:0] hold_res;
  logic [2:0]   hold_fl;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model in signed integer arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa   = longint'($signed(a));
    longint sb   = longint'($signed(b));
    longint maxs = (longint'(1) <<< (W - 1)) - 1;
    longint mins = -(longint'(1) <<< (W - 1));
    longint full;
    e.res = '0; e.ov = 1'b0; e.il = 1'b0;
    case (op)
      3'b000: begin full = sa + sb; e.res = full[W-1:0]; e.ov = (full > maxs) || (full < mins); end
      3'b001: begin full = sa - sb; e.res = full[W-1:0]; e.ov = (full > maxs) || (full < mins); end
      3'b010: e.res = a & b;
      3'b011: e.res = a | b;
      3'b101: e.res = (sa < sb) ? W'(1) : W'(0);
      default: e.il = 1'b1;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h0000_0001;
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: samples mid-cycle, pops expected result whenever a transfer is about to occur.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_n) begin
      hold_v = 1'b0;
      q.delete();
      cnt = 0;
    end else begin
      chk("op_count", 64'(op_count), 64'(cnt % (1 << CW)));
      if (hold_v) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_result", 64'(result), 64'(hold_res));
        chk("hold_flags", 64'({zero, overflow, illegal}), 64'(hold_fl));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          e = q.pop_front();
          chk("result", 64'(result), 64'(e.res));
          chk("zero", 64'(zero), 64'(e.z));
          chk("overflow", 64'(overflow), 64'(e.ov));
          chk("illegal", 64'(illegal), 64'(e.il));
          cnt++;
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_res = result;
      hold_fl  = {zero, overflow, illegal};
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    alu_control = op; src_a = a; src_b = b; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      q.push_back(model(op, a, b));
      @(negedge clk);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    chk(name, 64'(q.size()), 64'd0);
    chk({name, "_count"}, 64'(op_count), 64'(cnt % (1 << CW)));
  endtask

  initial begin
    in_valid = 1'b0; alu_control = 3'b000; src_a = '0; src_b = '0;
    out_ready = 1'b0; rst_n = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({zero, overflow, illegal}), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single op and latency.
    out_ready = 1'b1;
    send(ALU_ADD, 32'd5, 32'd7);
    in_valid = 1'b0;
    #2 chk("lat_not_yet", 64'(out_valid), 64'd0);
    @(negedge clk);
    #2 chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_result", 64'(result), 64'h0000_000C);
    @(negedge clk);

    // Directed corners streamed back to back.
    send(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
    send(ALU_SUB, 32'd3, 32'd3);
    send(ALU_SLT, 32'h8000_0000, 32'h1);
    send(ALU_SLT, 32'h1, 32'hFFFF_FFFF);
    send(ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000);
    send(3'b110, 32'hF0, 32'h0F);
    send(3'b100, 32'h1234, 32'h1);
    send(3'b111, 32'hFFFF_FFFF, 32'h0);
    send(ALU_SUB, 32'h8000_0000, 32'h1);
    drain("directed");

    // Backpressure: two accepts fill the pipe, then in_ready must drop.
    out_ready = 1'b0;
    send(ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
    send(ALU_OR,  32'hFF00_0000, 32'h0000_00FF);
    fork
      begin
        send(ALU_ADD, 32'd100, 32'd23);
        send(ALU_SUB, 32'd10, 32'd20);
        in_valid = 1'b0;
      end
      begin
        #1 chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain("backpressure");

    // Randomized traffic with random consumer stalls.
    done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
          end
          send(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand());
        end
        in_valid = 1'b0;
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
        end
      end
    join
    out_ready = 1'b1;
    drain("random");

    // Reset with two ops in flight.
    out_ready = 1'b0;
    send(ALU_ADD, 32'd1, 32'd2);
    send(ALU_OR, 32'd4, 32'd8);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_op_count", 64'(op_count), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_result", 64'(result), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    #2 chk("no_stale", 64'(out_valid), 64'd0);
    @(negedge clk);

    // Counter wrap: five completions on a 2-bit counter.
    for (int i = 0; i < 5; i++) send(ALU_ADD, W'(i), W'(i));
    drain("wrap");
    chk("wrap_value", 64'(op_count), 64'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
